bluetooth_rx: RTL and testbench

- UART receiver for the Bluetooth module link: 8N1, LSB first, 115200 baud.
- Driven by the same 8x-oversample tick enable (921.6 kHz) that paces the transmit side.
- Validates the start bit at mid-bit and samples each data bit and the stop bit at mid-bit.
- Delivers each byte through a single-entry holding register with a valid/ready handshake; flags framing errors and overruns.

---
 rtl/bluetooth_rx.sv | 149 ++++++++++++++
 tb/tb_bluetooth_rx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bluetooth_rx.sv
// 8N1 UART receiver for the Bluetooth module link, paced by an oversample tick enable.
// Mid-bit sampling of start/data/stop, single-entry holding register with valid/ready handshake.
module bluetooth_rx #(
   parameter int OVERSAMPLE  = 8,
   parameter int DATA_BITS   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_in,
   input  logic                 os_tick,
   input  logic                 rx,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int TICK_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
   localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync;
   logic                   rxs;
   logic [TICK_W-1:0]      tick_cnt;
   logic [BIT_W-1:0]       bit_cnt;
   logic [DATA_BITS-1:0]   shreg;

   // Input synchronizer: resets to the idle (high) line level.
   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         sync <= '1;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], rx};
      end
   end

   assign rxs = sync[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         state     <= ST_IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;

         // Consume; a completion later in this block overrides it.
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         if (os_tick) begin
            case (state)
               ST_IDLE: begin
                  if (!rxs) begin
                     state    <= ST_START;
                     busy     <= 1'b1;
                     tick_cnt <= '0;
                  end
               end

               ST_START: begin
                  if (tick_cnt == HALF_LAST) begin
                     if (rxs) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                     end else begin
                        state    <= ST_DATA;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end

               ST_DATA: begin
                  if (tick_cnt == TICK_LAST) begin
                     shreg    <= {rxs, shreg[DATA_BITS-1:1]};
                     tick_cnt <= '0;
                     bit_cnt  <= bit_cnt + 1'b1;
                     if (bit_cnt == BIT_LAST) begin
                        state <= ST_STOP;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end

               ST_STOP: begin
                  if (tick_cnt == TICK_LAST) begin
                     tick_cnt <= '0;
                     if (rxs) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        if (!rx_valid || rx_ready) begin
                           rx_data  <= shreg;
                           rx_valid <= 1'b1;
                        end else begin
                           overrun <= 1'b1;
                        end
                     end else begin
                        frame_err <= 1'b1;
                        state     <= ST_BREAK;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end

               // Held-low line: wait for it to return high before hunting for a new start bit.
               ST_BREAK: begin
                  if (rxs) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end

               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bluetooth_rx.sv
// Bench for bluetooth_rx: table-driven frames, hand-written corner sequences,
// then random frames checked against an in-order byte queue model.
module tb_bluetooth_rx;

   localparam int OS   = 8;
   localparam int TDIV = 4;

   logic       clk = 1'b0;
   logic       rst_in;
   logic       os_tick;
   logic       rx;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int tests = 0;
   int fails = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int both_viol = 0;
   int width_viol = 0;
   logic prev_fe = 1'b0;
   logic prev_ov = 1'b0;
   bit rand_mode = 1'b0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_valid;
      logic [7:0] exp_data;
      int         exp_fe;
   } vec_t;

   vec_t vecs[6];

   bluetooth_rx #(.OVERSAMPLE(OS), .DATA_BITS(8), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst_in    (rst_in),
      .os_tick   (os_tick),
      .rx        (rx),
      .rx_ready  (rx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // One-clk tick every TDIV clocks, changed on the falling edge.
   initial begin
      int div;
      div = 0;
      os_tick = 1'b0;
      forever begin
         @(negedge clk);
         div = (div + 1) % TDIV;
         os_tick = (div == 0);
      end
   end

   always @(negedge clk) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err && overrun) both_viol++;
      if ((frame_err && prev_fe) || (overrun && prev_ov)) width_viol++;
      prev_fe = frame_err;
      prev_ov = overrun;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Random consumer: handshake happens at the next rising edge, so compare now.
   initial begin
      forever begin
         @(negedge clk);
         if (rand_mode) begin
            rx_ready = 1'($urandom_range(1, 0));
            if (rx_valid && rx_ready) begin
               if (exp_q.size() == 0) check("rand_spurious_valid", 32'(rx_valid), 32'd0);
               else check("rand_byte", 32'(rx_data), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_tick();
      do @(posedge clk); while (!os_tick);
      #1;
   endtask

   task automatic pulse_ready();
      @(negedge clk);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      #1;
   endtask

   // Leaves rx at the stop-bit level; optional one-clk rx_ready on the stop-sample edge.
   task automatic send_frame(input logic [7:0] d, input logic stop, input bit ready_on_done);
      rx = 1'b1;
      repeat (2) wait_tick();
      rx = 1'b0;
      repeat (OS) wait_tick();
      for (int b = 0; b < 8; b++) begin
         rx = d[b];
         repeat (OS) wait_tick();
      end
      rx = stop;
      if (ready_on_done) begin
         repeat (OS / 2) wait_tick();
         do begin
            @(negedge clk);
            #1;
         end while (!os_tick);
         rx_ready = 1'b1;
         @(posedge clk);
         #1;
         rx_ready = 1'b0;
         repeat (OS / 2 - 1) wait_tick();
      end else begin
         repeat (OS) wait_tick();
      end
   endtask

   initial begin
      int fe0;
      int ov0;
      int nbad;
      logic [7:0] d;
      bit bad;

      rst_in = 1'b1;
      rx = 1'b1;
      rx_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rx_valid", 32'(rx_valid), 32'd0);
      check("reset_rx_data", 32'(rx_data), 32'd0);
      check("reset_frame_err", 32'(frame_err), 32'd0);
      check("reset_overrun", 32'(overrun), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_in = 1'b0;
      repeat (4) wait_tick();

      vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
      vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
      vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
      vecs[3] = '{8'h3C, 1'b0, 1'b0, 8'hFF, 1};
      vecs[4] = '{8'h11, 1'b1, 1'b1, 8'h11, 0};
      vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 0};

      for (int i = 0; i < 6; i++) begin
         fe0 = fe_cnt;
         ov0 = ov_cnt;
         send_frame(vecs[i].data, vecs[i].stop, 1'b0);
         if (!vecs[i].stop) begin
            repeat (3 * OS) wait_tick();
            check("vec_break_busy", 32'(busy), 32'd1);
            rx = 1'b1;
         end
         check("vec_rx_valid", 32'(rx_valid), 32'(vecs[i].exp_valid));
         check("vec_rx_data", 32'(rx_data), 32'(vecs[i].exp_data));
         check("vec_frame_err_count", 32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
         check("vec_overrun_count", 32'(ov_cnt - ov0), 32'd0);
         repeat (3) wait_tick();
         check("vec_busy_idle", 32'(busy), 32'd0);
         pulse_ready();
         check("vec_consumed", 32'(rx_valid), 32'd0);
      end

      // Start-bit glitch: low for two ticks only.
      fe0 = fe_cnt;
      rx = 1'b1;
      repeat (2) wait_tick();
      rx = 1'b0;
      repeat (2) wait_tick();
      rx = 1'b1;
      wait_tick();
      check("glitch_busy_in_start", 32'(busy), 32'd1);
      repeat (3) wait_tick();
      check("glitch_busy_after", 32'(busy), 32'd0);
      repeat (OS * 10) wait_tick();
      check("glitch_no_valid", 32'(rx_valid), 32'd0);
      check("glitch_no_frame_err", 32'(fe_cnt - fe0), 32'd0);

      // Overrun: second byte arrives while the first is still held.
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      send_frame(8'h01, 1'b1, 1'b0);
      check("ovr_first_valid", 32'(rx_valid), 32'd1);
      check("ovr_first_data", 32'(rx_data), 32'h01);
      send_frame(8'h02, 1'b1, 1'b0);
      check("ovr_count", 32'(ov_cnt - ov0), 32'd1);
      check("ovr_data_kept", 32'(rx_data), 32'h01);
      check("ovr_valid_kept", 32'(rx_valid), 32'd1);
      check("ovr_no_frame_err", 32'(fe_cnt - fe0), 32'd0);
      pulse_ready();
      check("ovr_consumed", 32'(rx_valid), 32'd0);

      // Back-to-back with rx_ready exactly on the completion edge.
      ov0 = ov_cnt;
      send_frame(8'h55, 1'b1, 1'b0);
      check("b2b_first_data", 32'(rx_data), 32'h55);
      send_frame(8'hAA, 1'b1, 1'b1);
      check("b2b_second_data", 32'(rx_data), 32'hAA);
      check("b2b_valid", 32'(rx_valid), 32'd1);
      check("b2b_no_overrun", 32'(ov_cnt - ov0), 32'd0);

      // Asynchronous reset in the middle of a data phase (0xF0 low nibble on the line).
      rx = 1'b1;
      repeat (2) wait_tick();
      rx = 1'b0;
      repeat (OS) wait_tick();
      repeat (3 * OS) wait_tick();
      check("rst_mid_busy_before", 32'(busy), 32'd1);
      @(posedge clk);
      #3;
      rst_in = 1'b1;
      #1;
      check("rst_mid_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_mid_rx_data", 32'(rx_data), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_frame_err", 32'(frame_err), 32'd0);
      check("rst_mid_overrun", 32'(overrun), 32'd0);
      rx = 1'b1;
      @(negedge clk);
      #2;
      rst_in = 1'b0;
      repeat (OS * 6) wait_tick();
      check("rst_after_busy", 32'(busy), 32'd0);
      check("rst_after_valid", 32'(rx_valid), 32'd0);
      send_frame(8'h0F, 1'b1, 1'b0);
      check("rst_next_valid", 32'(rx_valid), 32'd1);
      check("rst_next_data", 32'(rx_data), 32'h0F);
      pulse_ready();

      // Random frames, some with a low stop bit, against the in-order byte model.
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      nbad = 0;
      rand_mode = 1'b1;
      for (int n = 0; n < 40; n++) begin
         d = 8'($urandom);
         bad = ($urandom_range(7, 0) == 0);
         if (bad) nbad++;
         else exp_q.push_back(d);
         repeat ($urandom_range(6, 0)) wait_tick();
         send_frame(d, !bad, 1'b0);
         if (bad) begin
            repeat (OS) wait_tick();
            rx = 1'b1;
         end
      end
      repeat (2 * OS) wait_tick();
      @(posedge clk);
      #1;
      rand_mode = 1'b0;
      rx_ready = 1'b0;
      check("rand_queue_drained", 32'(exp_q.size()), 32'd0);
      check("rand_frame_err_count", 32'(fe_cnt - fe0), 32'(nbad));
      check("rand_overrun_count", 32'(ov_cnt - ov0), 32'd0);
      check("rand_final_valid", 32'(rx_valid), 32'd0);
      check("rand_final_busy", 32'(busy), 32'd0);

      check("pulse_exclusive", 32'(both_viol), 32'd0);
      check("pulse_width", 32'(width_viol), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
